// File: rtl/keypad_entry_if.sv
// Signal bundle between the keypad scanner side and the operand-entry
// sequencer. The master side drives the key register and its ready flag.
// The slave side (keypad_entry) drives the ALU and display outputs.
interface keypad_entry_if;
  logic [3:0] key_code;
  logic       key_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] opcode;
  logic       start;
  logic [7:0] disp_value;
  logic [1:0] phase;

  modport master (
    output key_code,
    output key_ready,
    input  op_a,
    input  op_b,
    input  opcode,
    input  start,
    input  disp_value,
    input  phase
  );

  modport slave (
    input  key_code,
    input  key_ready,
    output op_a,
    output op_b,
    output opcode,
    output start,
    output disp_value,
    output phase
  );
endinterface

// File: rtl/keypad_entry.sv
// Operand-entry sequencer: turns scanner key presses into single events,
// accumulates two decimal operands, selects the ALU operation and pulses
// start when '#' is pressed in ENTER_B.
//
// state   | meaning
// --------+------------------------------------------------------------
// ENTER_A | editing operand A; display shows op_a
// ENTER_B | operator chosen, editing operand B; display shows op_b
// DONE    | operation issued; operands and opcode frozen for the ALU
module keypad_entry #(
  parameter int MAX_VAL = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_entry_if.slave kp
);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    DONE    = 2'b10
  } state_t;

  localparam logic [11:0] MAX12 = 12'(MAX_VAL);

  state_t      state_q, state_n;
  logic        rdy_q;
  logic        pend;
  logic        evt;
  logic [7:0]  op_a_q, op_a_n;
  logic [7:0]  op_b_q, op_b_n;
  logic [1:0]  opcode_q, opcode_n;
  logic        start_q, start_n;
  logic [7:0]  disp_q, disp_n;
  logic        is_digit, is_op, is_eq, is_clr;
  logic [1:0]  opc_key;
  logic [7:0]  cur_val;
  logic [11:0] acc;
  logic        acc_ok;
  logic        digit_ok;

  // The key register lags the ready flag by a cycle, so the code is only
  // trusted one cycle after the rise, and only if ready is still high.
  assign evt = pend & kp.key_ready;

  assign is_digit = (kp.key_code < 4'd10);
  assign is_op    = (kp.key_code >= 4'd10) && (kp.key_code <= 4'd13);
  assign is_eq    = (kp.key_code == 4'd14);
  assign is_clr   = (kp.key_code == 4'd15);

  // A=10 -> 00, B=11 -> 01, C=12 -> 10, D=13 -> 11.
  assign opc_key = kp.key_code[1:0] ^ 2'b10;

  // Accumulate in 12 bits: 255*10+9 fits, so overflow is a plain compare.
  assign cur_val  = (state_q == ENTER_B) ? op_b_q : op_a_q;
  assign acc      = ({4'd0, cur_val} * 12'd10) + {8'd0, kp.key_code};
  assign acc_ok   = (acc <= MAX12);
  assign digit_ok = ({8'd0, kp.key_code} <= MAX12);

  // Press detection: rdy_q starts high so a key held through reset is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b1;
      pend  <= 1'b0;
    end else begin
      rdy_q <= kp.key_ready;
      pend  <= ~pend & kp.key_ready & ~rdy_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTER_A;
      op_a_q   <= 8'd0;
      op_b_q   <= 8'd0;
      opcode_q <= 2'b00;
      start_q  <= 1'b0;
      disp_q   <= 8'd0;
    end else begin
      state_q  <= state_n;
      op_a_q   <= op_a_n;
      op_b_q   <= op_b_n;
      opcode_q <= opcode_n;
      start_q  <= start_n;
      disp_q   <= disp_n;
    end
  end

  // Next-state and next-output decode for one accepted key event.
  always_comb begin
    state_n  = state_q;
    op_a_n   = op_a_q;
    op_b_n   = op_b_q;
    opcode_n = opcode_q;
    start_n  = 1'b0;

    if (evt) begin
      if (is_clr) begin
        state_n  = ENTER_A;
        op_a_n   = 8'd0;
        op_b_n   = 8'd0;
        opcode_n = 2'b00;
      end else begin
        case (state_q)
          ENTER_A: begin
            if (is_digit && acc_ok) begin
              op_a_n = acc[7:0];
            end else if (is_op) begin
              opcode_n = opc_key;
              op_b_n   = 8'd0;
              state_n  = ENTER_B;
            end
          end
          ENTER_B: begin
            if (is_digit && acc_ok) begin
              op_b_n = acc[7:0];
            end else if (is_op) begin
              opcode_n = opc_key;
            end else if (is_eq) begin
              state_n = DONE;
              start_n = 1'b1;
            end
          end
          DONE: begin
            // A digit after a result starts a fresh entry with that digit.
            if (is_digit) begin
              op_a_n  = digit_ok ? {4'd0, kp.key_code} : 8'd0;
              op_b_n  = 8'd0;
              state_n = ENTER_A;
            end
          end
          default: begin
            state_n  = ENTER_A;
            op_a_n   = 8'd0;
            op_b_n   = 8'd0;
            opcode_n = 2'b00;
          end
        endcase
      end
    end

    disp_n = (state_n == ENTER_A) ? op_a_n : op_b_n;
  end

  assign kp.op_a       = op_a_q;
  assign kp.op_b       = op_b_q;
  assign kp.opcode     = opcode_q;
  assign kp.start      = start_q;
  assign kp.disp_value = disp_q;
  assign kp.phase      = state_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active edge.
module tb_keypad_entry;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   start_cnt;

  keypad_entry_if kp ();

  keypad_entry #(.MAX_VAL(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every sampled cycle in which start is high.
  always @(negedge clk) begin
    if (kp.start === 1'b1) start_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code, input int hold = 5, input int gap = 5);
    @(negedge clk);
    kp.key_code  = code;
    kp.key_ready = 1'b1;
    cycles(hold);
    kp.key_ready = 1'b0;
    cycles(gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    kp.key_ready = 1'b0;
    kp.key_code  = 4'd0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    kp.key_ready = 1'b0;
    #1;
    tests++; if (kp.op_a !== 8'd0) begin fails++; $display("FAIL reset_op_a got %0d exp 0", kp.op_a); end
    tests++; if (kp.op_b !== 8'd0) begin fails++; $display("FAIL reset_op_b got %0d exp 0", kp.op_b); end
    tests++; if (kp.opcode !== 2'd0) begin fails++; $display("FAIL reset_opcode got %0d exp 0", kp.opcode); end
    tests++; if (kp.start !== 1'b0) begin fails++; $display("FAIL reset_start got %0b exp 0", kp.start); end
    tests++; if (kp.disp_value !== 8'd0) begin fails++; $display("FAIL reset_disp got %0d exp 0", kp.disp_value); end
    tests++; if (kp.phase !== 2'b00) begin fails++; $display("FAIL reset_phase got %0d exp 0", kp.phase); end
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_basic();
    int c0;
    press(4'd1);
    press(4'd2);
    tests++; if (kp.disp_value !== 8'd12) begin fails++; $display("FAIL basic_disp_a got %0d exp 12", kp.disp_value); end
    press(4'd10);
    press(4'd3);
    c0 = start_cnt;
    // '#' with the start pulse checked cycle by cycle.
    @(negedge clk);
    kp.key_code  = 4'd14;
    kp.key_ready = 1'b1;
    @(negedge clk);
    tests++; if (kp.start !== 1'b0) begin fails++; $display("FAIL basic_start_early got %0b exp 0", kp.start); end
    @(negedge clk);
    tests++; if (kp.start !== 1'b1) begin fails++; $display("FAIL basic_start_pulse got %0b exp 1", kp.start); end
    tests++; if (kp.op_a !== 8'd12) begin fails++; $display("FAIL basic_op_a_at_start got %0d exp 12", kp.op_a); end
    tests++; if (kp.op_b !== 8'd3) begin fails++; $display("FAIL basic_op_b_at_start got %0d exp 3", kp.op_b); end
    @(negedge clk);
    tests++; if (kp.start !== 1'b0) begin fails++; $display("FAIL basic_start_late got %0b exp 0", kp.start); end
    cycles(2);
    kp.key_ready = 1'b0;
    cycles(5);
    tests++; if (start_cnt - c0 !== 1) begin fails++; $display("FAIL basic_start_count got %0d exp 1", start_cnt - c0); end
    tests++; if (kp.opcode !== 2'b00) begin fails++; $display("FAIL basic_opcode got %0d exp 0", kp.opcode); end
    tests++; if (kp.phase !== 2'b10) begin fails++; $display("FAIL basic_phase got %0d exp 2", kp.phase); end
    tests++; if (kp.disp_value !== 8'd3) begin fails++; $display("FAIL basic_disp_done got %0d exp 3", kp.disp_value); end
  endtask

  task automatic test_restart_from_done();
    press(4'd5);
    tests++; if (kp.op_a !== 8'd5) begin fails++; $display("FAIL restart_op_a got %0d exp 5", kp.op_a); end
    tests++; if (kp.op_b !== 8'd0) begin fails++; $display("FAIL restart_op_b got %0d exp 0", kp.op_b); end
    tests++; if (kp.phase !== 2'b00) begin fails++; $display("FAIL restart_phase got %0d exp 0", kp.phase); end
    tests++; if (kp.disp_value !== 8'd5) begin fails++; $display("FAIL restart_disp got %0d exp 5", kp.disp_value); end
  endtask

  task automatic test_overflow();
    press(4'd15);
    press(4'd2);
    press(4'd5);
    press(4'd6);
    tests++; if (kp.op_a !== 8'd25) begin fails++; $display("FAIL ovf_256 got %0d exp 25", kp.op_a); end
    press(4'd0);
    tests++; if (kp.op_a !== 8'd250) begin fails++; $display("FAIL ovf_250 got %0d exp 250", kp.op_a); end
    press(4'd9);
    tests++; if (kp.op_a !== 8'd250) begin fails++; $display("FAIL ovf_2509 got %0d exp 250", kp.op_a); end
    tests++; if (kp.disp_value !== 8'd250) begin fails++; $display("FAIL ovf_disp got %0d exp 250", kp.disp_value); end
  endtask

  task automatic test_operator_replace();
    int c0;
    press(4'd15);
    c0 = start_cnt;
    press(4'd14);
    tests++; if (start_cnt !== c0) begin fails++; $display("FAIL eq_in_a_start got %0d exp %0d", start_cnt, c0); end
    tests++; if (kp.phase !== 2'b00) begin fails++; $display("FAIL eq_in_a_phase got %0d exp 0", kp.phase); end
    press(4'd7);
    press(4'd11);
    tests++; if (kp.opcode !== 2'b01) begin fails++; $display("FAIL op_b_sel got %0d exp 1", kp.opcode); end
    press(4'd12);
    press(4'd4);
    press(4'd14);
    tests++; if (kp.opcode !== 2'b10) begin fails++; $display("FAIL op_replace got %0d exp 2", kp.opcode); end
    tests++; if (kp.op_a !== 8'd7) begin fails++; $display("FAIL op_replace_a got %0d exp 7", kp.op_a); end
    tests++; if (kp.op_b !== 8'd4) begin fails++; $display("FAIL op_replace_b got %0d exp 4", kp.op_b); end
    tests++; if (start_cnt - c0 !== 1) begin fails++; $display("FAIL op_replace_start got %0d exp 1", start_cnt - c0); end
    c0 = start_cnt;
    press(4'd14);
    press(4'd13);
    tests++; if (start_cnt !== c0) begin fails++; $display("FAIL done_ignore_start got %0d exp %0d", start_cnt, c0); end
    tests++; if (kp.opcode !== 2'b10) begin fails++; $display("FAIL done_ignore_opcode got %0d exp 2", kp.opcode); end
    tests++; if (kp.op_a !== 8'd7 || kp.op_b !== 8'd4) begin fails++; $display("FAIL done_ignore_ops got %0d/%0d exp 7/4", kp.op_a, kp.op_b); end
    tests++; if (kp.phase !== 2'b10) begin fails++; $display("FAIL done_ignore_phase got %0d exp 2", kp.phase); end
  endtask

  task automatic test_clear_in_b();
    press(4'd3);
    press(4'd13);
    press(4'd4);
    tests++; if (kp.phase !== 2'b01) begin fails++; $display("FAIL clr_pre_phase got %0d exp 1", kp.phase); end
    press(4'd15);
    tests++; if (kp.op_a !== 8'd0) begin fails++; $display("FAIL clr_op_a got %0d exp 0", kp.op_a); end
    tests++; if (kp.op_b !== 8'd0) begin fails++; $display("FAIL clr_op_b got %0d exp 0", kp.op_b); end
    tests++; if (kp.opcode !== 2'b00) begin fails++; $display("FAIL clr_opcode got %0d exp 0", kp.opcode); end
    tests++; if (kp.phase !== 2'b00) begin fails++; $display("FAIL clr_phase got %0d exp 0", kp.phase); end
  endtask

  task automatic test_glitch_and_hold();
    press(4'd15);
    press(4'd8, 1, 5);
    tests++; if (kp.op_a !== 8'd0) begin fails++; $display("FAIL glitch got %0d exp 0", kp.op_a); end
    press(4'd3, 200, 5);
    tests++; if (kp.op_a !== 8'd3) begin fails++; $display("FAIL hold got %0d exp 3", kp.op_a); end
  endtask

  task automatic test_reset_held_key();
    @(negedge clk);
    rst_n        = 1'b0;
    kp.key_code  = 4'd6;
    kp.key_ready = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(10);
    tests++; if (kp.op_a !== 8'd0) begin fails++; $display("FAIL held_rst_op_a got %0d exp 0", kp.op_a); end
    tests++; if (kp.phase !== 2'b00) begin fails++; $display("FAIL held_rst_phase got %0d exp 0", kp.phase); end
    kp.key_ready = 1'b0;
    cycles(5);
    press(4'd6);
    tests++; if (kp.op_a !== 8'd6) begin fails++; $display("FAIL held_rst_repress got %0d exp 6", kp.op_a); end
  endtask

  task automatic test_reset_in_start();
    press(4'd15);
    press(4'd1);
    press(4'd10);
    press(4'd2);
    @(negedge clk);
    kp.key_code  = 4'd14;
    kp.key_ready = 1'b1;
    cycles(2);
    tests++; if (kp.start !== 1'b1) begin fails++; $display("FAIL rst_start_pre got %0b exp 1", kp.start); end
    rst_n        = 1'b0;
    kp.key_ready = 1'b0;
    #1;
    tests++; if (kp.start !== 1'b0) begin fails++; $display("FAIL rst_start_drop got %0b exp 0", kp.start); end
    tests++; if (kp.op_a !== 8'd0 || kp.op_b !== 8'd0) begin fails++; $display("FAIL rst_start_ops got %0d/%0d exp 0/0", kp.op_a, kp.op_b); end
    tests++; if (kp.phase !== 2'b00) begin fails++; $display("FAIL rst_start_phase got %0d exp 0", kp.phase); end
    tests++; if (kp.disp_value !== 8'd0) begin fails++; $display("FAIL rst_start_disp got %0d exp 0", kp.disp_value); end
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    start_cnt    = 0;
    rst_n        = 1'b0;
    kp.key_code  = 4'd0;
    kp.key_ready = 1'b0;
    test_reset();
    test_basic();
    test_restart_from_done();
    test_overflow();
    test_operator_replace();
    test_clear_in_b();
    test_glitch_and_hold();
    test_reset_held_key();
    test_reset_in_start();
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Operand-entry sequencer between the 4x4 keypad scanner and the ALU. It takes the scanner's registered 4-bit key code and level `ready` flag, and turns each key press into one event. Decimal digits are accumulated into two 8-bit operands; letter keys select the operation; `#` issues the operation and `*` clears. Its outputs feed the ALU operand/opcode inputs and the seven-segment display driver.

## Interface
- `MAX_VAL`, default 255: largest accepted operand value. Must be at most 255.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `key_code`  in  4  scanner key register. Mapping:
  - 0–9: digits.
  - 10 (A): add. 11 (B): sub. 12 (C): and. 13 (D): or.
  - 14 (#): equals.
  - 15 (*): clear.
- `key_ready`  in  1  scanner ready flag; high while a key is held.
- `op_a`  out  8  operand A.
- `op_b`  out  8  operand B.
- `opcode`  out  2  00 add, 01 sub, 10 and, 11 or.
- `start`  out  1  one-cycle pulse: operands and opcode are valid for the ALU.
- `disp_value`  out  8  operand currently being edited, for the display.
- `phase`  out  2  00 ENTER_A, 01 ENTER_B, 10 DONE (for LEDs).

## Operation
- Press detection:
  - `rdy_q` registers `key_ready` every cycle.
  - A rise is `key_ready & ~rdy_q` at edge T; it sets the `pend` flag.
  - At edge T+1, with `pend` set: if `key_ready` is still high, `key_code` is sampled and processed as one event. If it is low, the press is discarded.
  - `pend` clears at T+1 in both cases.
  - The one-cycle delay is required because the scanner's key register lags its ready flag by one cycle.
- Each physical press produces at most one event. A held key never repeats; the next event needs `key_ready` to go low and then rise again.
- Digit rule: `new = old*10 + d`, computed at 12 bits or wider.
  - If `new > MAX_VAL`, the digit is ignored and the operand is unchanged.
  - Leading zeros are accepted and leave the value at 0.
- ENTER_A:
  - digit: update `op_a`.
  - A–D: latch `opcode`, clear `op_b` to 0, go to ENTER_B.
  - `#`: ignored.
  - `*`: clear.
- ENTER_B:
  - digit: update `op_b`.
  - A–D: replace `opcode` and stay in ENTER_B.
  - `#`: go to DONE and pulse `start`.
  - `*`: clear.
- DONE:
  - `op_a`, `op_b` and `opcode` are held stable.
  - digit: clear `op_a` and `op_b`, then `op_a` = d. Go to ENTER_A.
  - A–D and `#`: ignored. A second `#` does not produce a second `start`.
  - `*`: clear.
- Clear: `op_a`, `op_b` and `opcode` go to 0; state goes to ENTER_A.
- `disp_value` shows `op_a` in ENTER_A, and `op_b` in ENTER_B and DONE.

## Timing
- All outputs are registered. Reset values:
  - `op_a`, `op_b`, `opcode`, `disp_value`, `start`, `pend`: all 0.
  - `phase` = 00 (ENTER_A).
  - `rdy_q` resets to **1**. A key held while reset is released is therefore ignored until it is released and pressed again.
- Latency: with `key_ready` rising before edge T, event effects (operands, `opcode`, `phase`, `disp_value`) are visible after edge T+1.
- `start` is high for exactly the one cycle following the T+1 edge that processes `#`, and low otherwise.
- When `start` is high, `op_a`, `op_b` and `opcode` already hold their final values. They stay unchanged until the next accepted event.
- `rst_n` asserted at any time, including with `pend` set or during the `start` cycle, clears everything at once. A pending event is lost and `start` drops immediately.
- A rise at edge T+1, while `pend` is still being serviced, cannot happen. `key_ready` was high at T, so no new rise is seen there.

## Test plan
- Basic sequence: reset, press 1, 2, A, 3, # (each press held 5 cycles, gaps of 5 cycles). Required:
  - `op_a`=12, `op_b`=3, `opcode`=00.
  - `start` is a single one-cycle pulse, 2 cycles after the `#` ready rise.
  - `phase`=10.
- Overflow: press 2, 5, 6 → `op_a` stays 25. Then press 0 → `op_a`=250. Then press 9 → `op_a` stays 250.
- Operator replace, and ignored keys:
  - In ENTER_A, press # → no `start`, `phase` stays 00.
  - 7, B, C, 4, # → `opcode`=10, `op_b`=4, `start` pulses once.
  - In DONE, press # and then D → no `start`, operands and `opcode` unchanged.
- Glitch and hold:
  - `key_ready` high for 1 cycle only → no event.
  - A key held for 200 cycles → exactly one digit accepted.
- Reset cases:
  - Key held across `rst_n` release → no event; after release and a new press, event accepted.
  - `rst_n` asserted in the `start` cycle → `start` goes to 0 immediately and all outputs return to reset values.
- Clear and restart:
  - From DONE (`op_a`=12), press 5 → `op_a`=5, `op_b`=0, `phase`=00.
  - From ENTER_B, press * → `op_a`=0, `op_b`=0, `opcode`=0, `phase`=00.
